// File: rtl/jtframe_joyser.sv
// Serial joystick reader: drives a PISO shift register and rebuilds two 6-bit active-low joystick buses.
// Latency: one frame = 34*CLKDIV clk cycles; joy1/joy2 update on the frame_done edge (two frames with debounce).
// Backpressure: none; free-running, outputs are held registers. Define JTFRAME_JOYSER_DEBOUNCE_EN to filter single-frame glitches.
module jtframe_joyser #(
    parameter int CLKDIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       joy_data,
    output logic       joy_clk,
    output logic       joy_load,
    output logic [5:0] joy1,
    output logic [5:0] joy2,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  div;
    logic        tick;
    logic [3:0]  bcnt;
    logic [15:0] sr;
    logic [5:0]  new1;
    logic [5:0]  new2;
    logic [11:0] upd;
    logic        unused_bits;

    assign tick = (div == 8'(CLKDIV - 1));

    // Serial index order per player: up, down, left, right, fire1, fire2.
    assign new1 = {sr[5],  sr[4],  sr[0], sr[1], sr[2],  sr[3]};
    assign new2 = {sr[13], sr[12], sr[8], sr[9], sr[10], sr[11]};

    // Bits 6, 7, 14 and 15 are shifted in but carry no joystick data.
    assign unused_bits = &{1'b0, sr[7:6], sr[15:14]};

    // Load is decoded from the state so a released reset starts a full-width load at once.
    assign joy_load = rst | (state != LOAD);

    // Tick divider: one enable pulse every CLKDIV clk cycles.
    always_ff @(posedge clk) begin
        if (rst)       div <= 8'd0;
        else if (tick) div <= 8'd0;
        else           div <= div + 8'd1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    // Next-state logic; every transition waits for a tick.
    always_comb begin
        state_nxt = state;
        if (tick) begin
            case (state)
                LOAD:    state_nxt = SHIFT;
                SHIFT:   if (joy_clk && bcnt == 4'd15) state_nxt = GAP;
                GAP:     state_nxt = LOAD;
                default: state_nxt = LOAD;
            endcase
        end
    end

    // Shift clock, bit counter and sample register; data is captured on the joy_clk rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            joy_clk    <= 1'b0;
            bcnt       <= 4'd0;
            sr         <= 16'hffff;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tick) begin
                case (state)
                    SHIFT: begin
                        if (!joy_clk) begin
                            sr[bcnt] <= joy_data;
                            joy_clk  <= 1'b1;
                        end else begin
                            joy_clk <= 1'b0;
                            // Stop at 15 instead of wrapping; the state machine leaves SHIFT here.
                            if (bcnt != 4'd15) bcnt <= bcnt + 4'd1;
                        end
                    end
                    GAP: begin
                        frame_done <= 1'b1;
                        bcnt       <= 4'd0;
                        joy_clk    <= 1'b0;
                    end
                    default: begin
                        bcnt    <= 4'd0;
                        joy_clk <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
    logic [11:0] prev;
    logic [11:0] same;

    // A bit follows the new frame only when it agrees with the previous frame.
    assign same = ~({new2, new1} ^ prev);
    assign upd  = ({new2, new1} & same) | ({joy2, joy1} & ~same);

    // Previous-frame history for the agreement check.
    always_ff @(posedge clk) begin
        if (rst)                        prev <= 12'hfff;
        else if (tick && state == GAP)  prev <= {new2, new1};
    end
`else
    assign upd = {new2, new1};
`endif

    // Both player buses are published together on the GAP tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            joy1 <= 6'h3f;
            joy2 <= 6'h3f;
        end else if (tick && state == GAP) begin
            joy1 <= upd[5:0];
            joy2 <= upd[11:6];
        end
    end

endmodule
